ray_march_engine: RTL and testbench
===================================

# ray_march_engine

Sequential, parametrised ray marcher for the rayMarcher pipeline. It accepts one ray (origin, direction) over a valid/ready handshake and iterates sphere-tracing steps. Each step is resolved through an external scene-distance (SDF) request/response port, so any scene module can be attached. It returns the hit distance, a hit/miss flag and the step count, and replaces the single-shot combinational marcher with a clocked, back-pressure-aware engine.

## Interface
- WIDTH, 32: bit width of every scalar (signed two's complement fixed point).
- FRAC, 16: fractional bits of every scalar.
- MAX_STEPS, 100: maximum SDF evaluations per ray (1..65535).
- MAX_DIST, 32'h0064_0000 (100.0): far-plane distance, in WIDTH/FRAC format.
- SURF_DIST, 32'h0000_028F (≈0.01): hit threshold, in WIDTH/FRAC format.
- STEP_W, 16: width of the step counter.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: ray presented.
- in_ready, output, 1: engine idle and accepting a ray.
- ro_x, ro_y, ro_z, input, WIDTH each: ray origin.
- rd_x, rd_y, rd_z, input, WIDTH each: ray direction (normalised by the producer; not checked).
- sdf_req_valid, output, 1: query position valid.
- sdf_req_ready, input, 1: scene accepts query.
- sdf_pos_x, sdf_pos_y, sdf_pos_z, output, WIDTH each: query position.
- sdf_resp_valid, input, 1: scene distance valid (one-cycle pulse).
- sdf_resp_dist, input, WIDTH: signed scene distance.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts result.
- out_dist, output, WIDTH: final ray distance t.
- out_hit, output, 1: 1 = surface hit, 0 = miss (far plane or step limit).
- out_steps, output, STEP_W: number of SDF evaluations performed.

## Operation
- States: IDLE, CALC, REQ, WAIT, UPD, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch ro/rd, set t=0, steps=0, go to CALC.
- CALC: pos = ro + ((rd*t) >>> FRAC) per axis. Product is 2*WIDTH signed, arithmetically shifted, truncated to WIDTH, then added with wrap (no saturation). Register pos, then go to REQ.
- REQ: sdf_req_valid=1 with pos stable. On sdf_req_ready go to WAIT.
- WAIT: on sdf_resp_valid, latch dS=sdf_resp_dist and go to UPD. A response arriving in any other state is ignored.
- UPD: t_next = t + dS (signed, wrap). steps_next = steps+1. Exit conditions are evaluated on t_next/dS in priority order:
  - t_next > MAX_DIST (signed compare) → DONE, hit=0.
  - dS < SURF_DIST (signed; negative dS counts as a hit) → DONE, hit=1.
  - steps_next == MAX_STEPS → DONE, hit=0.
  - otherwise → CALC.
- DONE: out_valid=1. out_dist=t, out_hit and out_steps are held stable. On out_ready go to IDLE.
- rst in any state: go to IDLE and abandon any outstanding SDF transaction. A late sdf_resp_valid after reset is ignored.

## Timing
- Reset values: in_ready=1 (IDLE), sdf_req_valid=0, sdf_pos_*=0, out_valid=0, out_dist=0, out_hit=0, out_steps=0.
- in_ready and out_valid are registered state decodes, with no combinational path from in_valid or out_ready.
- Per step: CALC 1 cycle, REQ ≥1 cycle, WAIT ≥1 cycle, UPD 1 cycle, so at least 4 cycles per step when the scene answers in the cycle after acceptance.
- Ray latency from accept to out_valid is at least 4*steps+1 cycles.
- sdf_req_valid is never withdrawn before the handshake, and sdf_pos_* stays constant while it is high.
- A new ray is accepted no earlier than the cycle after the DONE handshake (one ray in flight).

## Configuration
- RAY_MARCH_STEP_COUNT_EN.
  - Defined: the step counter is exported on out_steps.
  - Undefined: out_steps is tied to 0 and the counter is used only internally for the MAX_STEPS limit.
  - Termination behaviour is identical either way.

## Test plan
All values use FRAC=16.
- Plane scene dS = 5.0 − z, ro=(0,0,0), rd=(0,0,1.0) → out_hit=1, out_dist=32'h0005_0000, out_steps=2.
- Constant dS=30.0 → t = 30, 60, 90, 120 > 100, so out_hit=0, out_dist=32'h0078_0000, out_steps=4.
- Constant dS=0.5, MAX_STEPS=100 → out_hit=0, out_dist=32'h0032_0000, out_steps=100.
- First response dS = −1.0 → out_hit=1, out_dist=32'hFFFF_0000, out_steps=1.
- Back-pressure: hold sdf_req_ready=0 for 3 cycles with sdf_pos_* checked stable, and hold out_ready=0 for 5 cycles with outputs stable → same results as the plane case.
- Assert rst for 1 cycle while in WAIT, then send a stray sdf_resp_valid → engine is in IDLE with in_ready=1 and out_valid=0, and the next ray completes correctly.

Source files
------------

// File: rtl/ray_march_engine.sv
// Clocked sphere-tracing ray marcher; each step queries an external SDF port.
// Optional feature macro: RAY_MARCH_STEP_COUNT_EN exports the step counter on out_steps.
module ray_march_engine #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      FRAC      = 16,
  parameter int unsigned      MAX_STEPS = 100,
  parameter logic [WIDTH-1:0] MAX_DIST  = 32'h0064_0000,
  parameter logic [WIDTH-1:0] SURF_DIST = 32'h0000_028F,
  parameter int unsigned      STEP_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  ro_x,
  input  logic [WIDTH-1:0]  ro_y,
  input  logic [WIDTH-1:0]  ro_z,
  input  logic [WIDTH-1:0]  rd_x,
  input  logic [WIDTH-1:0]  rd_y,
  input  logic [WIDTH-1:0]  rd_z,
  output logic              sdf_req_valid,
  input  logic              sdf_req_ready,
  output logic [WIDTH-1:0]  sdf_pos_x,
  output logic [WIDTH-1:0]  sdf_pos_y,
  output logic [WIDTH-1:0]  sdf_pos_z,
  input  logic              sdf_resp_valid,
  input  logic [WIDTH-1:0]  sdf_resp_dist,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_dist,
  output logic              out_hit,
  output logic [STEP_W-1:0] out_steps
);

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StReq,
    StWait,
    StUpd,
    StDone
  } state_e;

  localparam logic [STEP_W-1:0] MaxSteps = STEP_W'(MAX_STEPS);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   ro_x_q, ro_y_q, ro_z_q, ro_x_d, ro_y_d, ro_z_d;
  logic [WIDTH-1:0]   rd_x_q, rd_y_q, rd_z_q, rd_x_d, rd_y_d, rd_z_d;
  logic [WIDTH-1:0]   pos_x_q, pos_y_q, pos_z_q, pos_x_d, pos_y_d, pos_z_d;
  logic [WIDTH-1:0]   t_q, t_d;
  logic [WIDTH-1:0]   ds_q, ds_d;
  logic [STEP_W-1:0]  steps_q, steps_d;
  logic               hit_q, hit_d;
  logic [WIDTH-1:0]   t_next;
  logic [STEP_W-1:0]  steps_next;

  // o + ((d * t) >>> FRAC), full-width signed product, truncated, wrapping add.
  function automatic logic [WIDTH-1:0] march_axis(input logic [WIDTH-1:0] o,
                                                  input logic [WIDTH-1:0] d,
                                                  input logic [WIDTH-1:0] t);
    logic signed [2*WIDTH-1:0] d_ext;
    logic signed [2*WIDTH-1:0] t_ext;
    logic signed [2*WIDTH-1:0] prod;
    d_ext = $signed({{WIDTH{d[WIDTH-1]}}, d});
    t_ext = $signed({{WIDTH{t[WIDTH-1]}}, t});
    prod  = (d_ext * t_ext) >>> FRAC;
    return o + WIDTH'(prod);
  endfunction

  assign t_next     = t_q + ds_q;
  assign steps_next = steps_q + STEP_W'(1);

  always_comb begin
    state_d = state_q;
    ro_x_d  = ro_x_q;
    ro_y_d  = ro_y_q;
    ro_z_d  = ro_z_q;
    rd_x_d  = rd_x_q;
    rd_y_d  = rd_y_q;
    rd_z_d  = rd_z_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    pos_z_d = pos_z_q;
    t_d     = t_q;
    ds_d    = ds_q;
    steps_d = steps_q;
    hit_d   = hit_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          ro_x_d  = ro_x;
          ro_y_d  = ro_y;
          ro_z_d  = ro_z;
          rd_x_d  = rd_x;
          rd_y_d  = rd_y;
          rd_z_d  = rd_z;
          t_d     = '0;
          steps_d = '0;
          hit_d   = 1'b0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        pos_x_d = march_axis(ro_x_q, rd_x_q, t_q);
        pos_y_d = march_axis(ro_y_q, rd_y_q, t_q);
        pos_z_d = march_axis(ro_z_q, rd_z_q, t_q);
        state_d = StReq;
      end
      StReq: begin
        if (sdf_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (sdf_resp_valid) begin
          ds_d    = sdf_resp_dist;
          state_d = StUpd;
        end
      end
      StUpd: begin
        t_d     = t_next;
        steps_d = steps_next;
        // Far plane beats surface hit, which beats the step limit.
        if ($signed(t_next) > $signed(MAX_DIST)) begin
          hit_d   = 1'b0;
          state_d = StDone;
        end else if ($signed(ds_q) < $signed(SURF_DIST)) begin
          hit_d   = 1'b1;
          state_d = StDone;
        end else if (steps_next == MaxSteps) begin
          hit_d   = 1'b0;
          state_d = StDone;
        end else begin
          state_d = StCalc;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ro_x_q  <= '0;
      ro_y_q  <= '0;
      ro_z_q  <= '0;
      rd_x_q  <= '0;
      rd_y_q  <= '0;
      rd_z_q  <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      pos_z_q <= '0;
      t_q     <= '0;
      ds_q    <= '0;
      steps_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ro_x_q  <= ro_x_d;
      ro_y_q  <= ro_y_d;
      ro_z_q  <= ro_z_d;
      rd_x_q  <= rd_x_d;
      rd_y_q  <= rd_y_d;
      rd_z_q  <= rd_z_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      pos_z_q <= pos_z_d;
      t_q     <= t_d;
      ds_q    <= ds_d;
      steps_q <= steps_d;
      hit_q   <= hit_d;
    end
  end

  assign in_ready      = (state_q == StIdle);
  assign sdf_req_valid = (state_q == StReq);
  assign out_valid     = (state_q == StDone);
  assign sdf_pos_x     = pos_x_q;
  assign sdf_pos_y     = pos_y_q;
  assign sdf_pos_z     = pos_z_q;
  assign out_dist      = t_q;
  assign out_hit       = hit_q;

`ifdef RAY_MARCH_STEP_COUNT_EN
  assign out_steps = steps_q;
`else
  // Counter still bounds the march; it is simply not exported.
  assign out_steps = '0;
`endif

endmodule

// File: tb/tb_ray_march_engine.sv
// Directed, table-driven bench for ray_march_engine with a behavioural SDF scene.
module tb_ray_march_engine;

  localparam int unsigned W = 32;

`ifdef RAY_MARCH_STEP_COUNT_EN
  localparam bit StepEn = 1'b1;
`else
  localparam bit StepEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  ro_x = '0, ro_y = '0, ro_z = '0;
  logic [W-1:0]  rd_x = '0, rd_y = '0, rd_z = '0;
  logic          sdf_req_valid;
  logic          sdf_req_ready = 1'b1;
  logic [W-1:0]  sdf_pos_x, sdf_pos_y, sdf_pos_z;
  logic          sdf_resp_valid;
  logic [W-1:0]  sdf_resp_dist;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_dist;
  logic          out_hit;
  logic [15:0]   out_steps;

  // Scene model: mode 0 is the plane z = 5.0, mode 1 returns a constant distance.
  logic          scene_en = 1'b1;
  int            scene_mode = 0;
  logic [W-1:0]  scene_ds = '0;
  logic          resp_scene = 1'b0;
  logic [W-1:0]  resp_scene_dist = '0;
  logic          resp_manual = 1'b0;
  logic [W-1:0]  resp_manual_dist = '0;

  assign sdf_resp_valid = resp_scene | resp_manual;
  assign sdf_resp_dist  = resp_manual ? resp_manual_dist : resp_scene_dist;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    resp_scene <= 1'b0;
    if (scene_en && sdf_req_valid && sdf_req_ready) begin
      resp_scene      <= 1'b1;
      resp_scene_dist <= (scene_mode == 0) ? (32'h0005_0000 - sdf_pos_z) : scene_ds;
    end
  end

  ray_march_engine dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ro_x           (ro_x),
    .ro_y           (ro_y),
    .ro_z           (ro_z),
    .rd_x           (rd_x),
    .rd_y           (rd_y),
    .rd_z           (rd_z),
    .sdf_req_valid  (sdf_req_valid),
    .sdf_req_ready  (sdf_req_ready),
    .sdf_pos_x      (sdf_pos_x),
    .sdf_pos_y      (sdf_pos_y),
    .sdf_pos_z      (sdf_pos_z),
    .sdf_resp_valid (sdf_resp_valid),
    .sdf_resp_dist  (sdf_resp_dist),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_dist       (out_dist),
    .out_hit        (out_hit),
    .out_steps      (out_steps)
  );

  typedef struct {
    string        name;
    int           mode;
    logic [W-1:0] ds;
    logic [W-1:0] ro_z;
    logic [W-1:0] rd_z;
    logic [W-1:0] exp_dist;
    logic         exp_hit;
    int           exp_steps;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic run_ray(input vec_t v, input int req_stall, input int out_hold);
    int cyc;
    logic [W-1:0] exp_steps;
    exp_steps  = StepEn ? W'(v.exp_steps) : '0;
    scene_mode = v.mode;
    scene_ds   = v.ds;
    @(negedge clk);
    check({v.name, "_in_ready"}, W'(in_ready), 1);
    ro_x = '0; ro_y = '0; ro_z = v.ro_z;
    rd_x = '0; rd_y = '0; rd_z = v.rd_z;
    in_valid      = 1'b1;
    sdf_req_ready = (req_stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    if (req_stall > 0) begin
      cyc = 0;
      while (!sdf_req_valid && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      for (int i = 0; i < req_stall; i++) begin
        check({v.name, "_req_held"}, W'(sdf_req_valid), 1);
        check({v.name, "_pos_z_stable"}, sdf_pos_z, v.ro_z);
        check({v.name, "_pos_x_stable"}, sdf_pos_x, 0);
        @(negedge clk);
      end
      sdf_req_ready = 1'b1;
    end
    cyc = 0;
    while (!out_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check({v.name, "_out_valid_timeout"}, W'(out_valid), 1);
    for (int i = 0; i < out_hold; i++) begin
      @(negedge clk);
      check({v.name, "_hold_valid"}, W'(out_valid), 1);
      check({v.name, "_hold_dist"}, out_dist, v.exp_dist);
      check({v.name, "_hold_hit"}, W'(out_hit), W'(v.exp_hit));
    end
    check({v.name, "_dist"}, out_dist, v.exp_dist);
    check({v.name, "_hit"}, W'(out_hit), W'(v.exp_hit));
    check({v.name, "_steps"}, W'(out_steps), exp_steps);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({v.name, "_out_valid_drop"}, W'(out_valid), 0);
    check({v.name, "_back_idle"}, W'(in_ready), 1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"plane",     0, 32'h0,         32'h0,         32'h0001_0000,
                32'h0005_0000, 1'b1, 2};
    vecs[1] = '{"far",       1, 32'h001E_0000, 32'h0,         32'h0001_0000,
                32'h0078_0000, 1'b0, 4};
    vecs[2] = '{"step_lim",  1, 32'h0000_8000, 32'h0,         32'h0001_0000,
                32'h0032_0000, 1'b0, 100};
    vecs[3] = '{"neg_hit",   1, 32'hFFFF_0000, 32'h0,         32'h0001_0000,
                32'hFFFF_0000, 1'b1, 1};
    vecs[4] = '{"plane_off", 0, 32'h0,         32'h0002_0000, 32'h0001_0000,
                32'h0003_0000, 1'b1, 2};

    repeat (2) @(negedge clk);
    check("rst_in_ready", W'(in_ready), 1);
    check("rst_req_valid", W'(sdf_req_valid), 0);
    check("rst_pos_x", sdf_pos_x, 0);
    check("rst_pos_z", sdf_pos_z, 0);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_out_dist", out_dist, 0);
    check("rst_out_hit", W'(out_hit), 0);
    check("rst_out_steps", W'(out_steps), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_ray(vecs[i], 0, 0);

    // Back-pressure on both the SDF request and the result.
    run_ray(vecs[0], 3, 5);

    // Reset while waiting on the scene, then a stray response.
    scene_en   = 1'b0;
    scene_mode = 0;
    @(negedge clk);
    ro_z = '0; rd_z = 32'h0001_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("wait_busy", W'(in_ready), 0);
    check("wait_no_req", W'(sdf_req_valid), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    resp_manual      = 1'b1;
    resp_manual_dist = 32'h0;
    @(negedge clk);
    resp_manual = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_in_ready", W'(in_ready), 1);
      check("post_rst_out_valid", W'(out_valid), 0);
      check("post_rst_req_valid", W'(sdf_req_valid), 0);
    end
    scene_en = 1'b1;
    run_ray(vecs[0], 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
